// File: rtl/t05_pkg.sv
// Shared types and constants for the t05 bit packer and its byte FIFO.
// The packer's optional trailing-CRC feature (T05_PACKER_CRC_EN) uses crc8_byte below.
package t05_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PACK,
    PAD,
    DRAIN,
    DONE
  } packer_state_t;

  localparam logic [3:0] EN_TRANSLATE  = 4'd5;
  localparam logic [3:0] EN_FINISH     = 4'd6;
  localparam logic [3:0] FIN_PACK_DONE = 4'd7;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // MSB-first CRC-8 update over one byte
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/t05_byte_fifo.sv
// Byte FIFO with a registered head: head always shows the oldest entry and is
// updated at the clock edge, so consumers see no combinational path from pop.
module t05_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign head  = head_q;

  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_ONE;
    end
    head_d = head_q;
    if (count_d != '0) begin
      // The new head is the byte being written when the FIFO drains to it this cycle
      if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/t05_bit_packer.sv
// Packs the serial code-bit stream MSB first into bytes, buffers them and drains on flush.
// Define T05_PACKER_CRC_EN to append a CRC-8 of the popped bytes and expose crc_out.
module t05_bit_packer
  import t05_pkg::*;
#(
  parameter int   FIFO_DEPTH = 8,
  parameter logic PAD_BIT    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en_state,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        flush,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [31:0] bits_total,
  output logic        overflow,
  output logic        done,
`ifdef T05_PACKER_CRC_EN
  output logic [7:0]  crc_out,
`endif
  output logic [3:0]  fin_state
);

  packer_state_t state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   bits_total_q, bits_total_d;
  logic          overflow_q, overflow_d;

  logic          active, accept;
  logic          push, pop;
  logic [7:0]    push_data;
  logic          fifo_full, fifo_empty;
  logic [3:0]    pad_sh;
  logic [7:0]    pad_byte;

`ifdef T05_PACKER_CRC_EN
  logic [7:0]    crc_q, crc_d;
  logic          crc_sent_q, crc_sent_d;
`endif

  assign active = (en_state == EN_TRANSLATE) || (en_state == EN_FINISH);
  assign pop    = byte_valid && byte_ready;

  // Left-align the partial byte; vacated low positions take PAD_BIT
  assign pad_sh   = 4'd8 - {1'b0, cnt_q};
  assign pad_byte = (sr_q << pad_sh) | (PAD_BIT ? ~(8'hFF << pad_sh) : 8'h00);

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    bits_total_d = bits_total_q;
    accept       = 1'b0;
    push         = 1'b0;
    push_data    = 8'h00;
`ifdef T05_PACKER_CRC_EN
    crc_sent_d   = crc_sent_q;
`endif

    if (active) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_d = DONE;
          end else if (en_state == EN_TRANSLATE) begin
            state_d = PACK;
            accept  = bit_valid;
          end
        end
        PACK: begin
          accept = bit_valid && (en_state == EN_TRANSLATE);
          if (flush) begin
            state_d = PAD;
          end
        end
        PAD: begin
          if (cnt_q != 3'd0) begin
            push      = 1'b1;
            push_data = pad_byte;
          end
          sr_d    = 8'h00;
          cnt_d   = 3'd0;
          state_d = DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
`ifdef T05_PACKER_CRC_EN
            if (!crc_sent_q) begin
              push       = 1'b1;
              push_data  = crc_q;
              crc_sent_d = 1'b1;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end
        end
        default: ;
      endcase
    end

    // DONE lasts exactly one cycle regardless of en_state
    if (state_q == DONE) begin
      state_d = IDLE;
`ifdef T05_PACKER_CRC_EN
      crc_sent_d = 1'b0;
`endif
    end

    if (accept) begin
      sr_d         = {sr_q[6:0], bit_in};
      bits_total_d = bits_total_q + 32'd1;
      if (cnt_q == 3'd7) begin
        push      = 1'b1;
        push_data = {sr_q[6:0], bit_in};
        cnt_d     = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end

    overflow_d = overflow_q | (push && fifo_full && !pop);
  end

`ifdef T05_PACKER_CRC_EN
  // The trailing CRC byte itself is not folded into the running CRC
  assign crc_d   = (pop && !crc_sent_q) ? crc8_byte(crc_q, byte_out) : crc_q;
  assign crc_out = crc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= 8'h00;
      cnt_q        <= 3'd0;
      bits_total_q <= 32'd0;
      overflow_q   <= 1'b0;
`ifdef T05_PACKER_CRC_EN
      crc_q        <= 8'h00;
      crc_sent_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      bits_total_q <= bits_total_d;
      overflow_q   <= overflow_d;
`ifdef T05_PACKER_CRC_EN
      crc_q        <= crc_d;
      crc_sent_q   <= crc_sent_d;
`endif
    end
  end

  t05_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (byte_out)
  );

  assign byte_valid = !fifo_empty;
  assign bits_total = bits_total_q;
  assign overflow   = overflow_q;
  assign done       = (state_q == DONE);
  assign fin_state  = (state_q == DONE) ? FIN_PACK_DONE : 4'd0;

endmodule

// File: tb/tb_t05_bit_packer.sv
// Directed testbench for t05_bit_packer: byte packing, padding, overflow, flush and reset.
module tb_t05_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  en_state = 4'd0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [31:0] bits_total;
  logic        overflow;
  logic        done;
  logic [3:0]  fin_state;
`ifdef T05_PACKER_CRC_EN
  logic [7:0]  crc_out;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [3:0]  fin_at_done = 4'd0;
  logic [7:0]  got_q[$];

  always #5 clk = ~clk;

  t05_bit_packer dut (
    .clk       (clk),
    .rst       (rst),
    .en_state  (en_state),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .bits_total(bits_total),
    .overflow  (overflow),
    .done      (done),
`ifdef T05_PACKER_CRC_EN
    .crc_out   (crc_out),
`endif
    .fin_state (fin_state)
  );

  // Inputs change 1ns after posedge, so the negedge sees the handshake that the next posedge takes
  always @(negedge clk) begin
    if (byte_valid && byte_ready) begin
      got_q.push_back(byte_out);
      $display("byte popped: 0x%02h", byte_out);
    end
    if (done) begin
      done_cnt++;
      fin_at_done = fin_state;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic with_flush);
    bit_in    = b;
    bit_valid = 1'b1;
    flush     = with_flush;
    tick(1);
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
  endtask

  task automatic wait_done(input int start_cnt, input string tag);
    int cyc;
    cyc = 0;
    while (done_cnt == start_cnt && cyc < 60) begin
      tick(1);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != start_cnt), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    logic [7:0] bits3;
    // ---- reset state
    #1 rst = 1'b1;
    #1;
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_out",   32'(byte_out),   32'd0);
    check("rst_bits_total", bits_total,      32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_fin_state",  32'(fin_state),  32'd0);
    tick(1);
    rst = 1'b0;

    // ---- test 1: two full bytes streamed with ready high
    en_state   = 4'd5;
    byte_ready = 1'b1;
    tick(1);
    send_byte(8'hA1);
    send_byte(8'h42);
    tick(4);
    check("t1_nbytes", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t1_byte0", 32'(got_q[0]), 32'hA1);
      check("t1_byte1", 32'(got_q[1]), 32'h42);
    end
    check("t1_bits_total", bits_total, 32'd16);
    got_q.delete();

    // ---- test 2: 3-bit partial byte padded on flush
    bits3 = 8'b0000_0110;
    for (int i = 2; i >= 0; i--) send_bit(bits3[i], 1'b0);
    d0    = done_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_done(d0, "t2");
    tick(3);
    check("t2_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t2_pad_byte", 32'(got_q[0]), 32'hC0);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t2_fin_state", 32'(fin_at_done), 32'd7);
    check("t2_fin_after", 32'(fin_state), 32'd0);
    check("t2_bits_total", bits_total, 32'd19);
    got_q.delete();

    // ---- test 3: FIFO fills with ready low, 9th byte dropped
    byte_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    tick(1);
    check("t3_full_no_ovf", 32'(overflow), 32'd0);
    send_byte(8'h18);
    tick(1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_head", 32'(byte_out), 32'h10);
    byte_ready = 1'b1;
    tick(12);
    check("t3_nbytes", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check($sformatf("t3_byte%0d", i), 32'(got_q[i]), 32'h10 + 32'(i));
    end
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_bits_total", bits_total, 32'd91);
    got_q.delete();

    // ---- test 4: flush together with the 8th bit, no pad byte
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    d0 = done_cnt;
    send_bit(1'b1, 1'b1);
    wait_done(d0, "t4");
    tick(3);
    check("t4_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t4_byte", 32'(got_q[0]), 32'h01);
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    got_q.delete();

    // ---- test 5: async reset mid-byte with 3 bytes queued
    byte_ready = 1'b0;
    en_state   = 4'd5;
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    check("t5_pre_valid", 32'(byte_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(byte_valid), 32'd0);
    check("t5_rst_bits_total", bits_total, 32'd0);
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    tick(1);
    rst        = 1'b0;
    byte_ready = 1'b1;
    tick(1);
    send_byte(8'h3C);
    tick(4);
    check("t5_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t5_clean_byte", 32'(got_q[0]), 32'h3C);
    check("t5_bits_total", bits_total, 32'd8);
    got_q.delete();

`ifdef T05_PACKER_CRC_EN
    // ---- test 6: "123456789" followed by its CRC-8 byte
    do_reset();
    en_state   = 4'd5;
    byte_ready = 1'b1;
    tick(1);
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
    d0    = done_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_done(d0, "t6");
    check("t6_nbytes", 32'(got_q.size()), 32'd10);
    if (got_q.size() == 10) check("t6_crc_byte", 32'(got_q[9]), 32'hF4);
    check("t6_crc_out", 32'(crc_out), 32'hF4);
    got_q.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
